noc_input_fifo: RTL and testbench

Receiving end of the router link handshake: accepts flits from an upstream router output port whose arbiter drives RTS and waits for DCTS, answers with a registered CTS pulse, and buffers flits in a small first-word-fall-through FIFO. Sits at each router input port. Read requests come from the five local output arbiters' grants.

---
 rtl/noc_pkg.sv | 26 ++
 rtl/noc_fifo_mem.sv | 42 ++++
 rtl/noc_input_fifo.sv | 99 +++++++++
 tb/tb_noc_input_fifo.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: default flit width, port indices and flit header field layout.
package noc_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;

    // Port indices shared by the output arbiters and the input FIFOs.
    typedef enum logic [2:0] {
        PORT_N = 3'd0,
        PORT_E = 3'd1,
        PORT_W = 3'd2,
        PORT_S = 3'd3,
        PORT_L = 3'd4
    } port_e;

    localparam int NUM_PORTS = 5;

    // Flit type lives in the top FLIT_TYPE_WIDTH bits of every flit.
    localparam int FLIT_TYPE_WIDTH = 3;

    function automatic logic [FLIT_TYPE_WIDTH-1:0] flit_type(
        input logic [DEFAULT_DATA_WIDTH-1:0] flit
    );
        return flit[DEFAULT_DATA_WIDTH-1 -: FLIT_TYPE_WIDTH];
    endfunction

endpackage

// File: rtl/noc_fifo_mem.sv
// Flit storage for the input FIFO: register array, one write port, combinational read port.
module noc_fifo_mem #(
    parameter int DATA_WIDTH = noc_pkg::DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = 4,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
    logic [DEPTH-1:0]      entry_we;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
            assign entry_we[gi] = wr_en && (wr_addr == ADDR_W'(gi));
        end
    endgenerate

    // Cleared on reset so the head flit reads as zero until the first write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (entry_we[i]) begin
                    mem_reg[i] <= wr_data;
                end
            end
        end
    end

    assign rd_data = mem_reg[rd_addr];

endmodule

// File: rtl/noc_input_fifo.sv
// Router input port: RTS/CTS receive handshake feeding a first-word-fall-through flit FIFO.
module noc_input_fifo #(
    parameter int DATA_WIDTH = noc_pkg::DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] RX,
    input  logic                  DRTS,
    output logic                  CTS,
    input  logic                  read_en_N,
    input  logic                  read_en_E,
    input  logic                  read_en_W,
    input  logic                  read_en_S,
    input  logic                  read_en_L,
    output logic [DATA_WIDTH-1:0] Data_out,
    output logic                  empty,
    output logic                  full
);
    import noc_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic                 cts_reg;
    logic                 empty_reg;
    logic                 full_reg;
    logic [PTR_W-1:0]     wr_ptr_reg;
    logic [PTR_W-1:0]     rd_ptr_reg;
    logic [CNT_W-1:0]     count_reg;
    logic [CNT_W-1:0]     count_next;
    logic [NUM_PORTS-1:0] rd_req;
    logic                 cts_in;
    logic                 read_en;

    always_comb begin
        rd_req         = '0;
        rd_req[PORT_N] = read_en_N;
        rd_req[PORT_E] = read_en_E;
        rd_req[PORT_W] = read_en_W;
        rd_req[PORT_S] = read_en_S;
        rd_req[PORT_L] = read_en_L;
    end

    // Gating on cts_reg keeps CTS to one cycle per flit even if DRTS lingers high.
    assign cts_in  = DRTS && !cts_reg && !full_reg;
    assign read_en = (|rd_req) && !empty_reg;

    always_comb begin
        count_next = count_reg;
        if (cts_in && !read_en) begin
            count_next = count_reg + CNT_W'(1);
        end else if (read_en && !cts_in) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cts_reg    <= 1'b0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            empty_reg  <= 1'b1;
            full_reg   <= 1'b0;
        end else begin
            cts_reg   <= cts_in;
            count_reg <= count_next;
            empty_reg <= (count_next == '0);
            full_reg  <= (count_next == DEPTH_CNT);
            if (cts_in) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (read_en) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
        end
    end

    noc_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (PTR_W)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (cts_in),
        .wr_addr (wr_ptr_reg),
        .wr_data (RX),
        .rd_addr (rd_ptr_reg),
        .rd_data (Data_out)
    );

    assign CTS   = cts_reg;
    assign empty = empty_reg;
    assign full  = full_reg;

endmodule

// File: tb/tb_noc_input_fifo.sv
// Bench for noc_input_fifo: directed vector table, hand sequences, and random traffic vs a queue model.
module tb_noc_input_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] rx = '0;
    logic          drts = 1'b0;
    logic          cts;
    logic [4:0]    rd = '0;   // bit0 N, 1 E, 2 W, 3 S, 4 L
    logic [DW-1:0] data_out;
    logic          empty;
    logic          full;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    noc_input_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .RX        (rx),
        .DRTS      (drts),
        .CTS       (cts),
        .read_en_N (rd[0]),
        .read_en_E (rd[1]),
        .read_en_W (rd[2]),
        .read_en_S (rd[3]),
        .read_en_L (rd[4]),
        .Data_out  (data_out),
        .empty     (empty),
        .full      (full)
    );

    typedef struct {
        logic          drts;
        logic [DW-1:0] rx;
        logic [4:0]    rd;
        logic          cts;
        logic          empty;
        logic          full;
        logic          dchk;
        logic [DW-1:0] data;
    } vec_t;

    vec_t tbl[22];

    function automatic vec_t mk(logic d, logic [DW-1:0] x, logic [4:0] r,
                                logic c, logic e, logic f, logic dc, logic [DW-1:0] dat);
        vec_t v;
        v.drts = d; v.rx = x; v.rd = r; v.cts = c; v.empty = e;
        v.full = f; v.dchk = dc; v.data = dat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [DW-1:0] q[$];
    logic          cts_m;
    logic [DW-1:0] held;

    initial begin
        // Empty FIFO after reset; row 0 starts from that state.
        tbl[0]  = mk(1, 32'hA5A5_0001, 5'b00000, 1, 0, 0, 1, 32'hA5A5_0001);
        tbl[1]  = mk(1, 32'hA5A5_0001, 5'b00000, 0, 0, 0, 1, 32'hA5A5_0001);
        tbl[2]  = mk(0, 32'h0,         5'b00000, 0, 0, 0, 1, 32'hA5A5_0001);
        tbl[3]  = mk(0, 32'h0,         5'b00010, 0, 1, 0, 0, 32'h0);
        // Fill with DRTS held high and RX incrementing.
        tbl[4]  = mk(1, 32'h10, 5'b00000, 1, 0, 0, 1, 32'h10);
        tbl[5]  = mk(1, 32'h11, 5'b00000, 0, 0, 0, 1, 32'h10);
        tbl[6]  = mk(1, 32'h12, 5'b00000, 1, 0, 0, 1, 32'h10);
        tbl[7]  = mk(1, 32'h13, 5'b00000, 0, 0, 0, 1, 32'h10);
        tbl[8]  = mk(1, 32'h14, 5'b00000, 1, 0, 0, 1, 32'h10);
        tbl[9]  = mk(1, 32'h15, 5'b00000, 0, 0, 0, 1, 32'h10);
        tbl[10] = mk(1, 32'h16, 5'b00000, 1, 0, 1, 1, 32'h10);
        tbl[11] = mk(1, 32'h17, 5'b00000, 0, 0, 1, 1, 32'h10);
        tbl[12] = mk(1, 32'h18, 5'b00000, 0, 0, 1, 1, 32'h10);
        tbl[13] = mk(1, 32'h19, 5'b00000, 0, 0, 1, 1, 32'h10);
        // Full with a simultaneous pop: no write that edge, write on the next.
        tbl[14] = mk(1, 32'h20, 5'b10000, 0, 0, 0, 1, 32'h12);
        tbl[15] = mk(1, 32'h20, 5'b00000, 1, 0, 1, 1, 32'h12);
        tbl[16] = mk(0, 32'h0,  5'b00000, 0, 0, 1, 1, 32'h12);
        // Several read enables at once are a single pop.
        tbl[17] = mk(0, 32'h0, 5'b01001, 0, 0, 0, 1, 32'h14);
        tbl[18] = mk(0, 32'h0, 5'b01101, 0, 0, 0, 1, 32'h16);
        tbl[19] = mk(0, 32'h0, 5'b11111, 0, 0, 0, 1, 32'h20);
        tbl[20] = mk(0, 32'h0, 5'b01000, 0, 1, 0, 1, 32'h12);
        // Read while empty: nothing moves, head slot (slot 2, holds 0x12) unchanged.
        tbl[21] = mk(0, 32'h0, 5'b00001, 0, 1, 0, 1, 32'h12);

        #12;
        chk("reset_cts",   {31'b0, cts},   0);
        chk("reset_empty", {31'b0, empty}, 1);
        chk("reset_full",  {31'b0, full},  0);
        chk("reset_data",  data_out,       0);
        rst = 1'b1;

        for (int i = 0; i < 22; i++) begin
            drts = tbl[i].drts; rx = tbl[i].rx; rd = tbl[i].rd;
            tick();
            $display("vec %0d drts=%0b rx=%08h rd=%05b -> cts=%0b empty=%0b full=%0b data=%08h",
                     i, drts, rx, rd, cts, empty, full, data_out);
            chk($sformatf("vec%0d_cts", i),   {31'b0, cts},   {31'b0, tbl[i].cts});
            chk($sformatf("vec%0d_empty", i), {31'b0, empty}, {31'b0, tbl[i].empty});
            chk($sformatf("vec%0d_full", i),  {31'b0, full},  {31'b0, tbl[i].full});
            if (tbl[i].dchk) chk($sformatf("vec%0d_data", i), data_out, tbl[i].data);
        end
        rd = '0;

        // Reset mid-transfer: CTS high with two flits stored.
        drts = 1; rx = 32'h55;
        tick();
        tick();
        rx = 32'h56;
        tick();
        chk("pre_reset_cts", {31'b0, cts}, 1);
        #2 rst = 1'b0;
        #1;
        $display("async reset -> cts=%0b empty=%0b full=%0b data=%08h", cts, empty, full, data_out);
        chk("arst_cts",   {31'b0, cts},   0);
        chk("arst_empty", {31'b0, empty}, 1);
        chk("arst_full",  {31'b0, full},  0);
        chk("arst_data",  data_out,       0);
        tick();
        chk("rst_hold_cts",   {31'b0, cts},   0);
        chk("rst_hold_empty", {31'b0, empty}, 1);
        #2 rst = 1'b1;
        rx = 32'h77;
        tick();
        $display("first edge after reset -> cts=%0b empty=%0b data=%08h", cts, empty, data_out);
        chk("post_rst_cts",   {31'b0, cts},   1);
        chk("post_rst_empty", {31'b0, empty}, 0);
        chk("post_rst_data",  data_out,       32'h77);
        drts = 0; rd = 5'b00010;
        tick();
        rd = '0;
        chk("post_rst_pop_empty", {31'b0, empty}, 1);

        // Pointer wrap: ten flits, each written then popped.
        for (int v = 1; v <= 10; v++) begin
            drts = 1; rx = DW'(v);
            tick();
            $display("wrap write %0d -> cts=%0b data=%08h", v, cts, data_out);
            chk($sformatf("wrap%0d_cts", v),  {31'b0, cts}, 1);
            chk($sformatf("wrap%0d_data", v), data_out, DW'(v));
            chk($sformatf("wrap%0d_flags", v), {31'b0, empty & full}, 0);
            drts = 0; rd = 5'b00010;
            tick();
            rd = '0;
            chk($sformatf("wrap%0d_empty", v), {31'b0, empty}, 1);
            chk($sformatf("wrap%0d_flags2", v), {31'b0, empty & full}, 0);
        end

        // Empty read leaves Data_out where it was.
        held = data_out;
        rd = 5'b11111;
        tick();
        rd = '0;
        chk("empty_read_data",  data_out, held);
        chk("empty_read_empty", {31'b0, empty}, 1);

        // Random traffic against a queue model.
        q.delete();
        cts_m = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            logic acc, pop;
            drts = ($urandom_range(0, 3) != 0);
            rx   = $urandom;
            rd   = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(1, 31)) : 5'b0;
            acc  = drts && !cts_m && (q.size() != DEPTH);
            pop  = (rd != 0) && (q.size() != 0);
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(rx);
            cts_m = acc;
            tick();
            if (n % 300 == 0)
                $display("rand %0d drts=%0b rd=%05b -> cts=%0b empty=%0b full=%0b size=%0d",
                         n, drts, rd, cts, empty, full, q.size());
            chk($sformatf("rand%0d_cts", n),   {31'b0, cts},   {31'b0, cts_m});
            chk($sformatf("rand%0d_empty", n), {31'b0, empty}, {31'b0, q.size() == 0});
            chk($sformatf("rand%0d_full", n),  {31'b0, full},  {31'b0, q.size() == DEPTH});
            if (q.size() != 0) chk($sformatf("rand%0d_data", n), data_out, q[0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
